// File: rtl/vending_machine_if.sv
// Coin-acceptor / actuator handshake between the front end and the vending controller.
interface vending_machine_if;
  logic din;
  logic qin;
  logic dispense;
  logic change;

  // Coin-acceptor side drives coins and watches the actuator strobes.
  modport master (output din, output qin, input dispense, input change);
  // Controller side samples coins and drives the actuator strobes.
  modport slave  (input din, input qin, output dispense, output change);
endinterface

// File: rtl/vending_machine.sv
// Single-product coin-operated vending controller built as a generic credit accumulator.
// Define VM_COIN_EDGE_EN to count a coin only on a 0->1 transition of din/qin.
module vending_machine #(
  parameter int unsigned PRICE       = 20,
  parameter int unsigned DIME_VAL    = 10,
  parameter int unsigned QUARTER_VAL = 25,
  parameter int unsigned CREDIT_W    = 6
) (
  input  logic              clk,
  input  logic              rstn,
  vending_machine_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(DIME_VAL);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER_VAL);

  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_change;

  logic                w_din_acc;
  logic                w_qin_acc;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_vend;

`ifdef VM_COIN_EDGE_EN
  logic r_din_q;
  logic r_qin_q;

  // Previous coin levels so a held input counts as a single coin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_din_q <= 1'b0;
      r_qin_q <= 1'b0;
    end else begin
      r_din_q <= bus.din;
      r_qin_q <= bus.qin;
    end
  end

  assign w_din_acc = bus.din & ~r_din_q;
  assign w_qin_acc = bus.qin & ~r_qin_q;
`else
  assign w_din_acc = bus.din;
  assign w_qin_acc = bus.qin;
`endif

  // Width constraint on CREDIT_W guarantees this sum never wraps.
  assign w_sum  = r_credit
                + (w_din_acc ? DIME_C    : '0)
                + (w_qin_acc ? QUARTER_C : '0);
  assign w_vend = (w_sum >= PRICE_C);

  // A purchase refunds all excess at once and clears credit; otherwise credit accumulates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_credit   <= '0;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
    end else if (w_vend) begin
      r_credit   <= '0;
      r_dispense <= 1'b1;
      r_change   <= (w_sum > PRICE_C);
    end else begin
      r_credit   <= w_sum;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
    end
  end

  assign bus.dispense = r_dispense;
  assign bus.change   = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine; expectations are hand-computed for default parameters.
module tb_vending_machine;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  vending_machine_if vif ();

  vending_machine dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_disp, input logic e_chg,
                            input int unsigned e_credit);
    chk({tag, ".dispense"}, 32'(vif.dispense), 32'(e_disp));
    chk({tag, ".change"},   32'(vif.change),   32'(e_chg));
    chk({tag, ".credit"},   32'(dut.r_credit), 32'(e_credit));
  endtask

  // Drive coins for one edge, then sample just after that edge.
  task automatic step(input logic d, input logic q);
    @(negedge clk);
    vif.din = d;
    vif.qin = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    vif.din = 1'b0;
    vif.qin = 1'b0;

    // Reset held with a dime present: nothing accumulates or fires.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      expect_out("reset_hold", 1'b0, 1'b0, 0);
    end
    @(negedge clk);
    vif.din = 1'b0;
    rstn    = 1'b1;

    // Quarter from zero, then asynchronous reset mid-cycle clears outputs at once.
    step(1'b0, 1'b1);
    expect_out("quarter_pre_async", 1'b1, 1'b1, 0);
    #1 rstn = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 0);
    vif.qin = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Two separated dimes: exact price, no change.
    step(1'b1, 1'b0); expect_out("dime1",     1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("dime_gap",  1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("dime2",     1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("dime_idle", 1'b0, 1'b0, 0);

    // Single quarter from zero.
    step(1'b0, 1'b1); expect_out("quarter",      1'b1, 1'b1, 0);
    step(1'b0, 1'b0); expect_out("quarter_idle", 1'b0, 1'b0, 0);

    // Dime then quarter, then a lone dime must not vend.
    step(1'b1, 1'b0); expect_out("dq_dime",    1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("dq_gap",     1'b0, 1'b0, 10);
    step(1'b0, 1'b1); expect_out("dq_quarter", 1'b1, 1'b1, 0);
    step(1'b0, 1'b0); expect_out("dq_idle",    1'b0, 1'b0, 0);
    step(1'b1, 1'b0); expect_out("dq_next",    1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("dq_next_gap",1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("dq_clear",   1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("dq_clear_idle", 1'b0, 1'b0, 0);

    // Simultaneous coins from zero.
    step(1'b1, 1'b1); expect_out("both",      1'b1, 1'b1, 0);
    step(1'b0, 1'b0); expect_out("both_idle", 1'b0, 1'b0, 0);

    // Simultaneous coins with 10 pending: 45 -> vend with change.
    step(1'b1, 1'b0); expect_out("both10_dime", 1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("both10_gap",  1'b0, 1'b0, 10);
    step(1'b1, 1'b1); expect_out("both10",      1'b1, 1'b1, 0);
    step(1'b0, 1'b0); expect_out("both10_idle", 1'b0, 1'b0, 0);

    // Pending credit is lost across reset with no refund.
    step(1'b1, 1'b0); expect_out("lost_dime", 1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("lost_gap",  1'b0, 1'b0, 10);
    #2 rstn = 1'b0;
    #1;
    expect_out("lost_reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0); expect_out("lost_after", 1'b0, 1'b0, 10);
    step(1'b0, 1'b0); expect_out("lost_after_gap", 1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("lost_clear", 1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("lost_clear_idle", 1'b0, 1'b0, 0);

`ifdef VM_COIN_EDGE_EN
    // Dime held 25 cycles counts once.
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'b0);
      expect_out("edge_din_hold", 1'b0, 1'b0, 10);
    end
    step(1'b0, 1'b0); expect_out("edge_din_rel",   1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("edge_din_clear", 1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("edge_din_idle",  1'b0, 1'b0, 0);
    // Quarter held 4 cycles vends once.
    step(1'b0, 1'b1); expect_out("edge_qin_first", 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      expect_out("edge_qin_hold", 1'b0, 1'b0, 0);
    end
    step(1'b0, 1'b0); expect_out("edge_qin_idle", 1'b0, 1'b0, 0);
`else
    // Dime held two cycles vends on the second edge.
    step(1'b1, 1'b0); expect_out("lvl_2d_c1", 1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("lvl_2d_c2", 1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("lvl_2d_idle", 1'b0, 1'b0, 0);
    // Dime held 25 cycles: vend on every even edge, never change.
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'b0);
      expect_out("lvl_din_hold", 1'((i % 2) == 0), 1'b0, ((i % 2) == 0) ? 0 : 10);
    end
    step(1'b0, 1'b0); expect_out("lvl_din_rel",   1'b0, 1'b0, 10);
    step(1'b1, 1'b0); expect_out("lvl_din_clear", 1'b1, 1'b0, 0);
    step(1'b0, 1'b0); expect_out("lvl_din_idle",  1'b0, 1'b0, 0);
    // Quarter held: vend with change every cycle.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      expect_out("lvl_qin_hold", 1'b1, 1'b1, 0);
    end
    step(1'b0, 1'b0); expect_out("lvl_qin_idle", 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
